// File: rtl/ram_march_tester.sv
// rtl/ram_march_tester.sv - four-phase march BIST initiator for the RAM8/RAM64 family
// Writes P(a), verifies, writes ~P(a), verifies; reports pass, first failing address/data and a mismatch count.
module ram_march_tester #(
   parameter int          ADDR_WIDTH = 3,
   parameter int          DATA_WIDTH = 16,
   parameter logic [15:0] SEED       = 16'hA5C3
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    start,
   output logic [DATA_WIDTH-1:0]   ram_in,
   output logic                    ram_load,
   output logic [ADDR_WIDTH-1:0]   ram_address,
   input  logic [DATA_WIDTH-1:0]   ram_out,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ADDR_WIDTH+1:0]   error_count,
   output logic [ADDR_WIDTH-1:0]   error_addr,
   output logic [DATA_WIDTH-1:0]   error_data
);

   localparam logic [DATA_WIDTH-1:0] KEY       = DATA_WIDTH'(SEED);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_WIDTH+1:0] CNT_ONE   = 1;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WRC,
      RDC,
      DONE
   } state_t;

   state_t state;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
      logic [DATA_WIDTH-1:0] p;
      p = DATA_WIDTH'(a) ^ KEY;
      return inv ? ~p : p;
   endfunction

   logic                  inv_phase;
   logic                  reading;
   logic                  last;
   logic                  mismatch;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [DATA_WIDTH-1:0] expected;

   always_comb begin
      inv_phase = (state == WRC) || (state == RDC);
      reading   = (state == RD) || (state == RDC);
      last      = &ram_address;
      next_addr = ram_address + ADDR_ONE;
      expected  = pat(ram_address, inv_phase);
      mismatch  = reading && (ram_out != expected);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         ram_in      <= '0;
         ram_load    <= 1'b0;
         ram_address <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         error_count <= '0;
         error_addr  <= '0;
         error_data  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               ram_load <= 1'b0;
               if (start) begin
                  error_count <= '0;
                  error_addr  <= '0;
                  error_data  <= '0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
                  ram_address <= '0;
                  ram_load    <= 1'b1;
                  ram_in      <= pat(ADDR_ZERO, 1'b0);
                  state       <= WR;
               end
            end

            WR, WRC: begin
               ram_address <= next_addr;
               if (last) begin
                  ram_load <= 1'b0;
                  state    <= (state == WR) ? RD : RDC;
               end else begin
                  ram_in <= pat(next_addr, inv_phase);
               end
            end

            RD, RDC: begin
               ram_address <= next_addr;
               if (mismatch) begin
                  if (!(&error_count))
                     error_count <= error_count + CNT_ONE;
                  if (error_count == '0) begin
                     error_addr <= ram_address;
                     error_data <= ram_out;
                  end
               end
               if (last) begin
                  if (state == RD) begin
                     ram_load <= 1'b1;
                     ram_in   <= pat(ADDR_ZERO, 1'b1);
                     state    <= WRC;
                  end else begin
                     // the final compare counts toward the verdict even though error_count updates on the same edge
                     pass  <= (error_count == '0) && !mismatch;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state    <= IDLE;
               ram_load <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
